// File: rtl/dpram_pkg.sv
// Shared types and default widths for the dual-port RAM port front ends.
package dpram_pkg;

  localparam int unsigned DPRAM_ADDR_W     = 8;
  localparam int unsigned DPRAM_DATA_W     = 8;
  localparam int unsigned DPRAM_DEPTH      = 4;
  localparam int unsigned DPRAM_RD_LATENCY = 1;

  typedef struct packed {
    logic                    we;
    logic [DPRAM_ADDR_W-1:0] addr;
    logic [DPRAM_DATA_W-1:0] wdata;
  } dpram_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    RESP
  } port_state_e;

endpackage

// File: rtl/dpram_cmd_fifo.sv
// Synchronous command FIFO; head entry is presented combinationally on o_rdata.
module dpram_cmd_fifo
  import dpram_pkg::*;
#(
  parameter int unsigned DEPTH = DPRAM_DEPTH,
  parameter type         T     = dpram_cmd_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  T                       i_wdata,
  input  logic                   i_pop,
  output T                       o_rdata,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  T                r_mem [DEPTH];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [PtrW:0]   r_count;
  logic            w_push;
  logic            w_pop;

  assign o_full  = (r_count == (PtrW + 1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PtrW + 1)'(1);
        2'b01:   r_count <= r_count - (PtrW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/dpram_port_master.sv
// Sequences buffered read/write commands onto one RAM port, one read outstanding at a time.
module dpram_port_master
  import dpram_pkg::*;
#(
  parameter int unsigned ADDR_W     = DPRAM_ADDR_W,
  parameter int unsigned DATA_W     = DPRAM_DATA_W,
  parameter int unsigned DEPTH      = DPRAM_DEPTH,
  parameter int unsigned RD_LATENCY = DPRAM_RD_LATENCY
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_we,
  input  logic [ADDR_W-1:0]      cmd_addr,
  input  logic [DATA_W-1:0]      cmd_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ADDR_W-1:0]      rsp_addr,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic [ADDR_W-1:0]      ram_addr,
  output logic [DATA_W-1:0]      ram_data,
  output logic                   ram_we,
  output logic                   ram_valid,
  input  logic                   ram_ready,
  input  logic [DATA_W-1:0]      ram_q,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   busy
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned LatW = $clog2(RD_LATENCY + 1);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  cmd_t              w_push_cmd;
  cmd_t              w_head;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_more;
  logic [CntW-1:0]   w_count;

  port_state_e       r_state;
  logic              r_ram_valid;
  logic [LatW-1:0]   r_lat_cnt;
  logic              r_rsp_valid;
  logic [ADDR_W-1:0] r_rsp_addr;
  logic [DATA_W-1:0] r_rsp_rdata;

  assign w_push_cmd = '{we: cmd_we, addr: cmd_addr, wdata: cmd_wdata};
  assign cmd_ready  = !w_full;
  assign w_push     = cmd_valid && !w_full;
  assign w_pop      = r_ram_valid && ram_ready;
  // Entries left once the head is popped, counting a command arriving on the same edge.
  assign w_more     = (w_count > CntW'(1)) || w_push;

  dpram_cmd_fifo #(
    .DEPTH (DEPTH),
    .T     (cmd_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_push_cmd),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // The FIFO head only advances on a handshake, so the request is stable under back-pressure.
  assign ram_valid  = r_ram_valid;
  assign ram_addr   = r_ram_valid ? w_head.addr  : '0;
  assign ram_data   = r_ram_valid ? w_head.wdata : '0;
  assign ram_we     = r_ram_valid ? w_head.we    : 1'b0;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_addr   = r_rsp_addr;
  assign rsp_rdata  = r_rsp_rdata;
  assign fifo_count = w_count;
  assign busy       = !w_empty || (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ram_valid <= 1'b0;
      r_lat_cnt   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_addr  <= '0;
      r_rsp_rdata <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_state     <= ISSUE;
            r_ram_valid <= 1'b1;
          end
        end
        ISSUE: begin
          if (ram_ready) begin
            if (w_head.we) begin
              if (!w_more) begin
                r_state     <= IDLE;
                r_ram_valid <= 1'b0;
              end
            end else begin
              r_state     <= WAIT_RD;
              r_ram_valid <= 1'b0;
              r_rsp_addr  <= w_head.addr;
              r_lat_cnt   <= LatW'(1);
            end
          end
        end
        WAIT_RD: begin
          if (r_lat_cnt == LatW'(RD_LATENCY)) begin
            r_rsp_rdata <= ram_q;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else begin
            r_lat_cnt <= r_lat_cnt + LatW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            if (!w_empty) begin
              r_state     <= ISSUE;
              r_ram_valid <= 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          r_ram_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dpram_port_master.sv
// Bench for dpram_port_master: RAM model plus in-order command/response scoreboard.
module tb_dpram_port_master;

  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LAT   = 3;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [AW-1:0] rsp_addr;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          ram_we;
  logic          ram_valid;
  logic          ram_ready;
  logic [DW-1:0] ram_q;
  logic [CW-1:0] fifo_count;
  logic          busy;

  dpram_port_master #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .DEPTH      (DEPTH),
    .RD_LATENCY (LAT)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_we     (cmd_we),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_addr   (rsp_addr),
    .rsp_rdata  (rsp_rdata),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .ram_we     (ram_we),
    .ram_valid  (ram_valid),
    .ram_ready  (ram_ready),
    .ram_q      (ram_q),
    .fifo_count (fifo_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_s;

  cmd_s          pend_q[$];
  cmd_s          exp_rsp[$];
  logic [DW-1:0] ram_mem [256];
  logic [DW-1:0] ref_mem [256];
  int            cyc;
  int            n_cmp;
  int            n_err;
  int            q_due;
  logic [DW-1:0] q_val;
  bit            rd_out;
  bit            prev_stall;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_data;
  logic          prev_we;
  logic [AW-1:0] last_raddr;
  logic [DW-1:0] last_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check at the negedge, account for handshakes of the coming edge, advance.
  task automatic tick();
    cmd_s c;
    ram_q = (cyc + 1 == q_due) ? q_val : DW'($urandom);
    if (!rst) begin
      chk("fifo_count", 32'(fifo_count), 32'(pend_q.size()));
      chk("cmd_ready", 32'(cmd_ready), 32'(pend_q.size() != DEPTH));
      chk("busy", 32'(busy), 32'(pend_q.size() != 0 || rd_out));
      if (prev_stall) begin
        chk("stall_valid", 32'(ram_valid), 1);
        chk("stall_addr", 32'(ram_addr), 32'(prev_addr));
        chk("stall_data", 32'(ram_data), 32'(prev_data));
        chk("stall_we", 32'(ram_we), 32'(prev_we));
      end
      if (ram_valid) begin
        chk("no_issue_while_rd", 32'(rd_out), 0);
        chk("issue_nonempty", 32'(pend_q.size() != 0), 1);
        if (pend_q.size() != 0) begin
          chk("ram_we_order", 32'(ram_we), 32'(pend_q[0].we));
          chk("ram_addr_order", 32'(ram_addr), 32'(pend_q[0].addr));
          if (pend_q[0].we) chk("ram_data_order", 32'(ram_data), 32'(pend_q[0].data));
        end
      end
      if (rd_out && cyc < q_due) begin
        chk("rsp_early", 32'(rsp_valid), 0);
      end else if (rd_out) begin
        chk("rsp_valid", 32'(rsp_valid), 1);
        chk("rsp_rdata_ram", 32'(rsp_rdata), 32'(q_val));
        if (exp_rsp.size() != 0) begin
          chk("rsp_addr", 32'(rsp_addr), 32'(exp_rsp[0].addr));
          chk("rsp_rdata_ref", 32'(rsp_rdata), 32'(exp_rsp[0].data));
        end
      end else begin
        chk("rsp_idle", 32'(rsp_valid), 0);
      end
      if (rsp_valid && rsp_ready && rd_out && exp_rsp.size() != 0) begin
        void'(exp_rsp.pop_front());
        last_raddr = rsp_addr;
        last_rdata = rsp_rdata;
        rd_out     = 1'b0;
        q_due      = -1;
      end
      if (ram_valid && ram_ready && pend_q.size() != 0) begin
        void'(pend_q.pop_front());
        if (ram_we) begin
          ram_mem[ram_addr] = ram_data;
        end else begin
          q_due  = cyc + 1 + int'(LAT);
          q_val  = ram_mem[ram_addr];
          rd_out = 1'b1;
        end
      end
      if (cmd_valid && cmd_ready) begin
        c.we   = cmd_we;
        c.addr = cmd_addr;
        c.data = cmd_wdata;
        pend_q.push_back(c);
        if (cmd_we) begin
          ref_mem[cmd_addr] = cmd_wdata;
        end else begin
          c.data = ref_mem[cmd_addr];
          exp_rsp.push_back(c);
        end
      end
      prev_stall = ram_valid && !ram_ready;
      prev_addr  = ram_addr;
      prev_data  = ram_data;
      prev_we    = ram_we;
    end
    @(posedge clk);
    cyc++;
    if (rst) begin
      // Flushed writes never reached the RAM, so the reference falls back to RAM contents.
      pend_q.delete();
      exp_rsp.delete();
      rd_out     = 1'b0;
      q_due      = -1;
      prev_stall = 1'b0;
      for (int i = 0; i < 256; i++) ref_mem[i] = ram_mem[i];
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst       = 1'b1;
    cmd_valid = 1'b0;
    ram_ready = 1'b0;
    rsp_ready = 1'b0;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic send(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit acc;
    int budget;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = a;
    cmd_wdata = d;
    acc       = 1'b0;
    budget    = 50;
    while (!acc && budget > 0) begin
      acc = cmd_ready;
      tick();
      budget--;
    end
    cmd_valid = 1'b0;
    chk("send_accepted", 32'(acc), 1);
  endtask

  task automatic drain(input int budget);
    cmd_valid = 1'b0;
    ram_ready = 1'b1;
    rsp_ready = 1'b1;
    while ((pend_q.size() != 0 || rd_out) && budget > 0) begin
      tick();
      budget--;
    end
    chk("drain_done", 32'(pend_q.size() != 0 || rd_out), 0);
  endtask

  initial begin
    int budget;
    n_cmp = 0;
    n_err = 0;
    cyc   = 0;
    q_due = -1;
    rd_out     = 1'b0;
    prev_stall = 1'b0;
    cmd_we     = 1'b0;
    cmd_addr   = '0;
    cmd_wdata  = '0;
    ram_q      = '0;
    last_raddr = '0;
    last_rdata = '0;
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = '0;
      ref_mem[i] = '0;
    end
    rst = 1'b1;
    @(negedge clk);
    do_reset(2);

    // Reset state
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_addr", 32'(rsp_addr), 0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
    chk("rst_ram_valid", 32'(ram_valid), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ram_data", 32'(ram_data), 0);
    chk("rst_fifo_count", 32'(fifo_count), 0);
    chk("rst_busy", 32'(busy), 0);
    repeat (3) tick();

    // Write then read back, RAM always ready
    ram_ready = 1'b1;
    rsp_ready = 1'b1;
    send(1'b1, 8'h10, 8'hA5);
    chk("no_bypass", 32'(ram_valid), 0);
    send(1'b0, 8'h10, 8'h00);
    chk("wr_beat_valid", 32'(ram_valid), 1);
    chk("wr_beat_we", 32'(ram_we), 1);
    chk("wr_beat_addr", 32'(ram_addr), 32'h10);
    tick();
    chk("rd_beat_valid", 32'(ram_valid), 1);
    chk("rd_beat_we", 32'(ram_we), 0);
    drain(30);
    chk("wr_rd_addr", 32'(last_raddr), 32'h10);
    chk("wr_rd_data", 32'(last_rdata), 32'hA5);

    // Fill the FIFO under RAM back-pressure, then drain in order
    ram_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1;
      cmd_we    = (i != 2);
      cmd_addr  = AW'(8'h40 + i);
      cmd_wdata = DW'($urandom);
      tick();
    end
    cmd_valid = 1'b0;
    chk("full_count", 32'(fifo_count), 4);
    chk("full_cmd_ready", 32'(cmd_ready), 0);
    repeat (3) tick();
    drain(60);

    // Response back-pressure holds the port
    ram_ready = 1'b1;
    rsp_ready = 1'b0;
    send(1'b0, 8'h40, 8'h00);
    send(1'b1, 8'h30, 8'h5A);
    budget = 20;
    while (!rsp_valid && budget > 0) begin
      tick();
      budget--;
    end
    for (int i = 0; i < 3; i++) begin
      chk("rsp_hold_valid", 32'(rsp_valid), 1);
      chk("rsp_hold_no_issue", 32'(ram_valid), 0);
      tick();
    end
    drain(30);

    // Reset during WAIT_RD with two queued commands
    ram_ready = 1'b1;
    rsp_ready = 1'b0;
    send(1'b0, 8'h20, 8'h00);
    send(1'b1, 8'h21, 8'h11);
    send(1'b1, 8'h22, 8'h22);
    budget = 20;
    while (!(rd_out && cyc < q_due && pend_q.size() == 2) && budget > 0) begin
      tick();
      budget--;
    end
    chk("reached_wait_rd", 32'(rd_out && cyc < q_due), 1);
    do_reset(1);
    chk("mid_rst_count", 32'(fifo_count), 0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
    chk("mid_rst_ram_valid", 32'(ram_valid), 0);
    chk("mid_rst_rsp_addr", 32'(rsp_addr), 0);
    rsp_ready = 1'b1;
    ram_ready = 1'b1;
    repeat (10) tick();

    // Randomized traffic over a small address window
    for (int i = 0; i < 600; i++) begin
      cmd_valid = ($urandom_range(0, 1) == 1);
      cmd_we    = ($urandom_range(0, 1) == 1);
      cmd_addr  = AW'($urandom_range(0, 15));
      cmd_wdata = DW'($urandom);
      ram_ready = ($urandom_range(0, 9) < 7);
      rsp_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    drain(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
